div_unit: RTL

Iterative 32-bit divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits directly downstream of the register file in the execute stage. It consumes the two source-operand read values and the destination register index. It returns a quotient or remainder, together with that index, on the write-back path that feeds the register file write port. Normal operations take 33 cycles. Divide-by-zero and signed overflow finish in one cycle.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// sign correction in a final FIX cycle, one-cycle shortcut for div-by-zero and overflow.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | 32 restoring steps on magnitudes
// FIX   | apply signs, register result
// DONE  | one-cycle done pulse; may accept the next op
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_rd_addr
);

  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state, state_nx;
  logic [5:0]      cnt;
  logic [XLEN-1:0] rem, quo, divs;
  logic [4:0]      rd_q;
  logic            op_rem, neg_q, neg_r;

  logic            in_signed, in_rem, accept, div_zero, ovf, special;
  logic [XLEN-1:0] special_res, dividend_mag, divisor_mag;
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] rem_nx, quo_nx, q_fix, r_fix, fix_res;

  always_comb begin
    in_signed    = (funct3 == F3_DIV) || (funct3 == F3_REM);
    in_rem       = (funct3 == F3_REM) || (funct3 == F3_REMU);
    accept       = start && !flush && ((state == IDLE) || (state == DONE));
    div_zero     = (rs2_data == '0);
    ovf          = in_signed && (rs1_data == MIN_NEG) && (rs2_data == ALL_ONES);
    special      = div_zero || ovf;
    if (div_zero) special_res = in_rem ? rs1_data : ALL_ONES;
    else          special_res = in_rem ? '0 : MIN_NEG;
    dividend_mag = (in_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
    divisor_mag  = (in_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
  end

  // The shifted partial remainder needs XLEN+1 bits; after a successful
  // subtract it is always below the divisor, so XLEN bits are stored.
  always_comb begin
    rem_sh  = {rem, quo[XLEN-1]};
    ge      = (rem_sh >= {1'b0, divs});
    rem_nx  = ge ? (rem_sh[XLEN-1:0] - divs) : rem_sh[XLEN-1:0];
    quo_nx  = {quo[XLEN-2:0], ge};
    q_fix   = neg_q ? -quo : quo;
    r_fix   = neg_r ? -rem : rem;
    fix_res = op_rem ? r_fix : q_fix;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = special ? DONE : CALC;
      CALC:    if (cnt == 6'd31) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = accept ? (special ? DONE : CALC) : IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      divs       <= '0;
      rd_q       <= '0;
      op_rem     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      result     <= '0;
      wb_rd_addr <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cnt    <= '0;
        rem    <= '0;
        quo    <= dividend_mag;
        divs   <= divisor_mag;
        rd_q   <= rd_addr;
        op_rem <= in_rem;
        neg_q  <= in_signed && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
        neg_r  <= in_signed && rs1_data[XLEN-1];
        if (special) begin
          result     <= special_res;
          wb_rd_addr <= rd_addr;
        end
      end else if ((state == CALC) && !flush) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 6'd1;
      end else if ((state == FIX) && !flush) begin
        result     <= fix_res;
        wb_rd_addr <= rd_q;
      end
    end
  end

  assign busy = (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule
